// File: rtl/line_fill_server.sv
// Instruction-cache line-fill engine: reads the 8 words of a missing line from a
// synchronous ROM and streams them back as write beats. Optional macro: CRIT_WORD_FIRST_EN.
module line_fill_server #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              sync_reset_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              abort,
  output logic              rom_rd_en,
  output logic [ADDR_W-1:0] rom_rd_addr,
  input  logic [DATA_W-1:0] rom_rd_data,
  output logic              fill_valid,
  output logic [ADDR_W-4:0] fill_line,
  output logic [2:0]        fill_offset,
  output logic [DATA_W-1:0] fill_data,
  output logic              fill_last,
  output logic              fill_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t              r_state;
  logic [ADDR_W-4:0]   r_line;
  logic [2:0]          r_off;
  logic [2:0]          r_cnt;
  logic                r_done;
  logic [ROM_LAT-1:0]  r_pv;
  logic [ROM_LAT-1:0]  r_pl;
  logic [2:0]          r_po [ROM_LAT];
  logic [2:0]          w_start;
  logic                w_last;

`ifdef CRIT_WORD_FIRST_EN
  assign w_start = req_addr[2:0];
`else
  logic w_unused_word;
  assign w_unused_word = ^req_addr[2:0];
  assign w_start       = '0;
`endif

  // Tail of the latency pipeline lines up with rom_rd_data for the same read.
  assign w_last      = r_pv[ROM_LAT-1] & r_pl[ROM_LAT-1];
  assign req_ready   = (r_state == IDLE);
  assign rom_rd_en   = (r_state == ISSUE);
  assign rom_rd_addr = {r_line, r_off};
  assign fill_line   = r_line;
  assign fill_valid  = r_pv[ROM_LAT-1];
  assign fill_offset = r_pv[ROM_LAT-1] ? r_po[ROM_LAT-1] : '0;
  assign fill_data   = r_pv[ROM_LAT-1] ? rom_rd_data : '0;
  assign fill_last   = w_last;
  assign fill_done   = r_done;

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      r_state <= IDLE;
      r_line  <= '0;
      r_off   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_pv    <= '0;
      r_pl    <= '0;
      for (int unsigned i = 0; i < ROM_LAT; i++) r_po[i] <= '0;
    end else begin
      r_done <= 1'b0;
      for (int unsigned i = 1; i < ROM_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pl[i] <= r_pl[i-1];
        r_po[i] <= r_po[i-1];
      end
      r_pv[0] <= (r_state == ISSUE);
      r_pl[0] <= (r_cnt == 3'd7);
      r_po[0] <= r_off;

      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_line  <= req_addr[ADDR_W-1:3];
            r_off   <= w_start;
            r_cnt   <= '0;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_off <= r_off + 3'd1;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_last) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Abort wins over everything above; the beat already on the outputs this cycle is still seen.
      if (abort && r_state != IDLE) begin
        r_state <= IDLE;
        r_pv    <= '0;
        r_done  <= 1'b0;
      end
    end
  end

endmodule
